cache_assoc: RTL
================

# cache_assoc

Parametrised set-associative, write-through, no-write-allocate cache between the CPU request port and the memory port. It generalises the existing direct-mapped cache in associativity, set count, line width and data width, adds an explicit invalidate strobe and a completion handshake, and uses round-robin replacement. The bus formats keep the current 33-bit request layout at default parameters.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 8, CPU data width (one byte)
- LINE_BYTES, 2, bytes per line; power of two; MEM_W = DATA_W*LINE_BYTES
- SETS, 8, number of sets; power of two
- WAYS, 2, associativity; one of 1, 2, 4
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- cpu_request  in  1+DATA_W+ADDR_W  {we, wdata, addr}
- cpu_request_ready  in  1  request valid (level)
- invalidate_address  in  ADDR_W  line to invalidate
- invalidate_valid  in  1  invalidate strobe, one cycle
- memory_request  out  1+MEM_W+ADDR_W  {we, data, addr}; fills use a line-aligned addr and data=0; writes put the byte in data[DATA_W-1:0]
- memory_request_ready  out  1  memory request valid
- memory_response  in  MEM_W  fill line
- memory_response_ready  in  1  fill data or write acknowledge valid
- data_out  out  DATA_W  read byte, or the written byte on a write
- data_out_ready  out  1  completion, one-cycle pulse

## Operation
- Address split: offset = addr[log2(LINE_BYTES)-1:0], index next log2(SETS) bits, tag = remainder. Byte k of a line is line[k*DATA_W +: DATA_W].
- States: IDLE, LOOKUP, FILL_REQ, WRITE_REQ, RESP, DONE.
- IDLE: when cpu_request_ready=1, register the request and go to LOOKUP.
- LOOKUP: compare the tag against all valid ways in the set.
  - Read hit: go to RESP.
  - Read miss: go to FILL_REQ.
  - Write: go to WRITE_REQ. On a hit, update the cached byte in the same cycle. On a miss, no allocation.
- FILL_REQ: hold memory_request_ready=1. On the first cycle memory_response_ready=1:
  - Write the line into the victim way, set its valid bit, and go to RESP.
  - Victim: the lowest-index invalid way; if all ways are valid, the way named by the set's round-robin pointer, and the pointer then increments modulo WAYS.
- WRITE_REQ: hold memory_request_ready=1 until memory_response_ready=1, then go to RESP.
- RESP: drive data_out, pulse data_out_ready, go to DONE.
- DONE: wait for cpu_request_ready=0, then go to IDLE. This guarantees each request is serviced exactly once.
- Invalidate: accepted in any state; clears the valid bit of the way whose tag matches invalidate_address in its set.
  - Same cycle as LOOKUP on the same line: invalidate wins and the lookup is a miss.
  - Same line during FILL_REQ: the fill data is still returned to the CPU, but the line is left invalid.
  - Same cycle as a fill write of the same line: the line is left invalid.

## Timing
- Reset: all outputs 0, state IDLE, every valid bit and round-robin pointer cleared. Data and tag arrays need no reset.
- Reset mid-operation aborts the access. memory_request_ready is 0 in the cycle after reset is sampled, and any in-flight response is ignored.
- Read hit: request sampled at edge 0; data_out_ready high in the cycle after edge 2.
- Miss and write: data_out_ready rises one cycle after the edge that samples memory_response_ready.
- memory_request_ready deasserts on the cycle after the response is sampled. The memory side must drop memory_response_ready within one cycle.
- memory_request and data_out are stable while their ready signal is high.

## Configuration
- CACHE_ASSOC_STATS_EN defined: adds output ports hit_count[31:0] and miss_count[31:0].
  - Each increments once per LOOKUP; writes count as well.
  - Both counters saturate at all-ones and clear on reset.
- CACHE_ASSOC_STATS_EN undefined: the ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Package cache_assoc_pkg holds:
  - the state enum;
  - localparams for OFFSET_W, INDEX_W, TAG_W, MEM_W and the request/response field offsets;
  - the request struct {we, wdata, addr}.
- Sub-module cache_assoc_way, instantiated WAYS times: one way's tag, valid and data arrays, with a combinational hit output, a fill write port, a byte-write port and an invalidate port.
- Replacement pointers and the FSM live in the top level.

## Test plan
- Cold read: read addr 0x000D, memory returns 0x3700 → fill request addr 0x000C; data_out=0x37. Re-read 0x000C → hit, data_out=0x00, no memory request.
- Write hit: write 0xA5 to 0x000C after the fill → memory_request={1,0x00A5,0x000C}. Then read 0x000C → hit, 0xA5.
- Write miss: write 0x11 to 0x0100 → memory write issued. Read 0x0100 → miss, confirming no allocation.
- Replacement, WAYS=2: fill 0x0010, 0x0020, then 0x0030 (evicts way 0). Read 0x0020 → hit; read 0x0010 → miss.
- Invalidate: after filling 0x0020, pulse invalidate_valid with invalidate_address=0x0021. Read 0x0020 → miss. Repeat with the pulse during FILL_REQ → data returned, next read misses.
- Reset during FILL_REQ → memory_request_ready=0 the next cycle, all lines invalid. With STATS_EN, the counters read 0.

Source files
------------

// File: rtl/cache_assoc_pkg.sv
// cache_assoc_pkg: shared state enum, request struct and default geometry for cache_assoc
package cache_assoc_pkg;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_LINE_BYTES = 2;
    localparam int DEF_SETS       = 8;
    localparam int DEF_WAYS       = 2;
    localparam int OFFSET_W       = $clog2(DEF_LINE_BYTES);
    localparam int INDEX_W        = $clog2(DEF_SETS);
    localparam int TAG_W          = DEF_ADDR_W - OFFSET_W - INDEX_W;
    localparam int MEM_W          = DEF_DATA_W * DEF_LINE_BYTES;
    localparam int REQ_ADDR_LSB   = 0;
    localparam int REQ_WDATA_LSB  = DEF_ADDR_W;
    localparam int REQ_WE_BIT     = DEF_ADDR_W + DEF_DATA_W;
    localparam int MREQ_DATA_LSB  = DEF_ADDR_W;
    localparam int MREQ_WE_BIT    = DEF_ADDR_W + MEM_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL_REQ, WRITE_REQ, RESP, DONE} state_t;

    typedef struct packed {
        logic                  we;
        logic [DEF_DATA_W-1:0] wdata;
        logic [DEF_ADDR_W-1:0] addr;
    } cpu_req_t;

    function automatic int ptr_w(input int ways);
        return ways > 1 ? $clog2(ways) : 1;
    endfunction
endpackage

// File: rtl/cache_assoc_way.sv
// cache_assoc_way: one way's tag, valid and data arrays with fill, byte-write and invalidate ports
module cache_assoc_way #(
    parameter int SETS   = 8,
    parameter int IW     = 3,
    parameter int TW     = 12,
    parameter int MW     = 16,
    parameter int OW     = 1,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IW-1:0]     idx,
    input  logic [TW-1:0]     tag,
    output logic              hit,
    output logic              valid,
    output logic [MW-1:0]     line,
    input  logic              fill_en,
    input  logic              fill_valid,
    input  logic [MW-1:0]     fill_line,
    input  logic              bw_en,
    input  logic [OW-1:0]     bw_off,
    input  logic [DATA_W-1:0] bw_byte,
    input  logic              inv_en,
    input  logic [IW-1:0]     inv_idx,
    input  logic [TW-1:0]     inv_tag
);
    logic [TW-1:0]   tags [SETS];
    logic [MW-1:0]   data [SETS];
    logic [SETS-1:0] valids;

    assign valid = valids[idx];
    assign hit   = valids[idx] && tags[idx] == tag;
    assign line  = data[idx];

    // valid bits: a fill overrides a same-cycle invalidate of the old line in this slot
    always_ff @(posedge clock) begin
        if (reset) begin
            valids <= '0;
        end else begin
            if (inv_en && valids[inv_idx] && tags[inv_idx] == inv_tag) valids[inv_idx] <= 1'b0;
            if (fill_en) valids[idx] <= fill_valid;
        end
    end

    // tag and data storage, no reset needed
    always_ff @(posedge clock) begin
        if (fill_en) begin
            tags[idx] <= tag;
            data[idx] <= fill_line;
        end else if (bw_en) begin
            data[idx][bw_off*DATA_W +: DATA_W] <= bw_byte;
        end
    end
endmodule

// File: rtl/cache_assoc.sv
// cache_assoc: set-associative write-through no-write-allocate cache with round-robin replacement
// Define CACHE_ASSOC_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_assoc
    import cache_assoc_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_BYTES = DEF_LINE_BYTES,
    parameter int SETS       = DEF_SETS,
    parameter int WAYS       = DEF_WAYS
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [DATA_W+ADDR_W:0]             cpu_request,
    input  logic                               cpu_request_ready,
    input  logic [ADDR_W-1:0]                  invalidate_address,
    input  logic                               invalidate_valid,
    output logic [DATA_W*LINE_BYTES+ADDR_W:0]  memory_request,
    output logic                               memory_request_ready,
    input  logic [DATA_W*LINE_BYTES-1:0]       memory_response,
    input  logic                               memory_response_ready,
    output logic [DATA_W-1:0]                  data_out,
    output logic                               data_out_ready
`ifdef CACHE_ASSOC_STATS_EN
    ,
    output logic [31:0]                        hit_count,
    output logic [31:0]                        miss_count
`endif
);
    localparam int OW = $clog2(LINE_BYTES);
    localparam int IW = $clog2(SETS);
    localparam int TW = ADDR_W - OW - IW;
    localparam int MW = DATA_W * LINE_BYTES;
    localparam int PW = ptr_w(WAYS);

    state_t            state, state_next;
    logic              req_we, inv_pend;
    logic [DATA_W-1:0] req_wdata, resp_byte;
    logic [ADDR_W-1:0] req_addr;
    logic [IW-1:0]     idx;
    logic [OW-1:0]     off;
    logic [WAYS-1:0]   hits, vbits, fill_sel, bw_sel;
    logic [MW-1:0]     lines [WAYS];
    logic [MW-1:0]     hit_line;
    logic [PW-1:0]     rr [SETS];
    logic [PW-1:0]     victim;
    logic              any_hit, inv_line, fill_done, fill_valid;

    assign idx        = req_addr[OW +: IW];
    assign off        = req_addr[OW-1:0];
    assign inv_line   = invalidate_valid && ((invalidate_address ^ req_addr) >> OW) == '0;
    assign any_hit    = |hits && !inv_line;
    assign fill_done  = state == FILL_REQ && memory_response_ready;
    assign fill_valid = !(inv_pend || inv_line);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign fill_sel[w] = fill_done && victim == PW'(w);
        assign bw_sel[w]   = state == LOOKUP && req_we && any_hit && hits[w];
        cache_assoc_way #(
            .SETS(SETS), .IW(IW), .TW(TW), .MW(MW), .OW(OW), .DATA_W(DATA_W)
        ) u_way (
            .clock(clock),
            .reset(reset),
            .idx(idx),
            .tag(req_addr[ADDR_W-1 -: TW]),
            .hit(hits[w]),
            .valid(vbits[w]),
            .line(lines[w]),
            .fill_en(fill_sel[w]),
            .fill_valid(fill_valid),
            .fill_line(memory_response),
            .bw_en(bw_sel[w]),
            .bw_off(off),
            .bw_byte(req_wdata),
            .inv_en(invalidate_valid),
            .inv_idx(invalidate_address[OW +: IW]),
            .inv_tag(invalidate_address[ADDR_W-1 -: TW])
        );
    end

    // hit-way line mux and victim choice: lowest invalid way, else the set's round-robin pointer
    always_comb begin
        hit_line = '0;
        victim   = rr[idx];
        for (int i = WAYS - 1; i >= 0; i--) begin
            hit_line = hit_line | (hits[i] ? lines[i] : '0);
            victim   = vbits[i] ? victim : PW'(i);
        end
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:                state_next = cpu_request_ready ? LOOKUP : IDLE;
            LOOKUP:              state_next = req_we ? WRITE_REQ : any_hit ? RESP : FILL_REQ;
            FILL_REQ, WRITE_REQ: state_next = memory_response_ready ? RESP : state;
            RESP:                state_next = DONE;
            DONE:                state_next = cpu_request_ready ? DONE : IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // memory port outputs: line-aligned fill or single-byte write-through
    always_comb begin
        memory_request_ready = state == FILL_REQ || state == WRITE_REQ;
        memory_request = state == FILL_REQ  ? {1'b0, MW'(0), req_addr[ADDR_W-1:OW], OW'(0)}
                       : state == WRITE_REQ ? {1'b1, MW'(req_wdata), req_addr} : '0;
    end

    // request capture, response byte, pending-invalidate flag and registered CPU outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            req_we         <= 1'b0;
            req_wdata      <= '0;
            req_addr       <= '0;
            resp_byte      <= '0;
            inv_pend       <= 1'b0;
            data_out       <= '0;
            data_out_ready <= 1'b0;
        end else begin
            if (state == IDLE && cpu_request_ready) {req_we, req_wdata, req_addr} <= cpu_request;
            if (state == LOOKUP) begin
                resp_byte <= req_we ? req_wdata : hit_line[off*DATA_W +: DATA_W];
                inv_pend  <= 1'b0;
            end
            if (state == FILL_REQ && inv_line) inv_pend <= 1'b1;
            if (fill_done) resp_byte <= memory_response[off*DATA_W +: DATA_W];
            data_out_ready <= state == RESP;
            data_out       <= state == RESP ? resp_byte : '0;
        end
    end

    // round-robin pointer advances only when a fill replaces a valid line
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else if (fill_done && &vbits) begin
            rr[idx] <= rr[idx] == PW'(WAYS - 1) ? '0 : rr[idx] + 1'b1;
        end
    end

`ifdef CACHE_ASSOC_STATS_EN
    // saturating lookup statistics, writes included
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (any_hit && !(&hit_count)) hit_count <= hit_count + 1'b1;
            if (!any_hit && !(&miss_count)) miss_count <= miss_count + 1'b1;
        end
    end
`endif
endmodule
